// File: rtl/scope_trigger.sv
// Trigger/capture controller in front of the 64-bit trace scope: arms on request,
// fires on a masked level/edge match, streams DEPTH timestamped samples, then holds off.
module scope_trigger #(
    parameter int unsigned PROBE_W = 48,
    parameter int unsigned TS_W    = 16,
    parameter int unsigned DEPTH   = 16384,
    parameter logic [31:0] HOLDOFF = 32'd30000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               arm,
    input  logic               abort,
    input  logic [PROBE_W-1:0] trig_mask,
    input  logic [PROBE_W-1:0] trig_value,
    input  logic               trig_edge,
    input  logic [PROBE_W-1:0] probe,
    output logic [63:0]        trace_in,
    output logic               trace_en,
    output logic               armed,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_HOLDOFF
    } state_t;

    localparam logic [31:0] DEPTH_C   = 32'(DEPTH);
    // A zero holdoff still spends one cycle in HOLDOFF.
    localparam logic [31:0] HOLD_LOAD = (HOLDOFF == 32'd0) ? 32'd0 : HOLDOFF - 32'd1;

    state_t               state_q, state_d;
    logic [PROBE_W-1:0]   probe_q, probe_d;
    logic                 match_q, match_d;
    logic                 done_q, done_d;
    logic                 trace_en_q, trace_en_d;
    logic [63:0]          trace_in_q, trace_in_d;
    logic [31:0]          sample_cnt_q, sample_cnt_d;
    logic [31:0]          hold_cnt_q, hold_cnt_d;

    logic                 match;
    logic                 fire;
    logic                 arm_accept;
    logic                 capture_end;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            probe_q      <= '0;
            match_q      <= 1'b1;
            done_q       <= 1'b0;
            trace_en_q   <= 1'b0;
            trace_in_q   <= '0;
            sample_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            probe_q      <= probe_d;
            match_q      <= match_d;
            done_q       <= done_d;
            trace_en_q   <= trace_en_d;
            trace_in_q   <= trace_in_d;
            sample_cnt_q <= sample_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    always_comb begin
        match       = (((probe_q ^ trig_value) & trig_mask) == '0);
        fire        = (state_q == S_ARMED) && match && (!trig_edge || !match_q);
        arm_accept  = (state_q == S_IDLE) && arm && !abort;
        capture_end = abort || (sample_cnt_q == DEPTH_C);
    end

    // Next-state and datapath
    always_comb begin
        state_d      = state_q;
        probe_d      = probe;
        match_d      = match;
        done_d       = done_q;
        trace_en_d   = trace_en_q;
        trace_in_d   = trace_in_q;
        sample_cnt_d = sample_cnt_q;
        hold_cnt_d   = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (arm_accept) begin
                    state_d = S_ARMED;
                    done_d  = 1'b0;
                    match_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (fire) begin
                    state_d      = S_CAPTURE;
                    trace_en_d   = 1'b1;
                    trace_in_d   = {{TS_W{1'b0}}, probe_q};
                    sample_cnt_d = 32'd1;
                end
            end
            S_CAPTURE: begin
                if (capture_end) begin
                    state_d    = S_HOLDOFF;
                    trace_en_d = 1'b0;
                    done_d     = 1'b1;
                    hold_cnt_d = HOLD_LOAD;
                end else begin
                    trace_en_d   = 1'b1;
                    trace_in_d   = {sample_cnt_q[TS_W-1:0], probe_q};
                    sample_cnt_d = sample_cnt_q + 32'd1;
                end
            end
            S_HOLDOFF: begin
                if (hold_cnt_q == 32'd0) begin
                    state_d = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        trace_in = trace_in_q;
        trace_en = trace_en_q;
        done     = done_q;
        armed    = (state_q == S_ARMED);
        busy     = (state_q == S_CAPTURE) || (state_q == S_HOLDOFF);
    end

endmodule
